line_fetch_scheduler: RTL and testbench

- Sequences per-scanline background/mask image fetches from the shared SDRAM burst port (port 0) into the background and mask pixel FIFOs.
- Arbitrates that port between image-download writes and display reads.
- Sits between the video timing generator, the SDRAM burst controller and the two image FIFOs.
- Owns address generation, burst restart/termination, and packing three 16-bit words into one 24-bit background pixel and one 24-bit mask pixel.

---
 rtl/line_fetch_scheduler.sv | 167 ++++++++++++++++
 tb/tb_line_fetch_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_scheduler.sv
// Per-scanline background/mask fetch sequencer on SDRAM port 0, with download-write arbitration.
// Optional build macro LINE_FETCH_STATS_EN adds a saturating underrun_count output.
module line_fetch_scheduler #(
    parameter int WORDS_PER_LINE = 2160,
    parameter int LINES          = 720,
    parameter int ADDR_W         = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hblank,
    input  logic [9:0]        video_y,
    input  logic              download,
    input  logic              wr_req_in,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              sd_data_available,
    input  logic [15:0]       sd_q,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_rd_req,
    output logic              sd_wr_req,
    output logic              sd_end_burst,
    output logic              fifo_wrreq,
    output logic [23:0]       bg_pixel,
    output logic [23:0]       mask_pixel,
    output logic              fifo_clear,
    output logic              line_done
`ifdef LINE_FETCH_STATS_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int              CNT_W   = $clog2(WORDS_PER_LINE + 1);
    localparam logic [CNT_W-1:0] WPL    = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] WPL_M2 = CNT_W'(WORDS_PER_LINE - 2);
    localparam logic [10:0]     LINES_C = 11'(LINES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic              hblank_q;
    logic              avail_q;
    logic              end_sent;
    logic [CNT_W-1:0]  count;
    logic [1:0]        pack;
    logic [ADDR_W-1:0] base;

    logic              line_start;
    logic              restart;
    logic              fetching;
    logic              accept;
    logic              avail_fall;
    logic [10:0]       y_next;
    logic [ADDR_W-1:0] base_next;

    // NOTE: y_next gets a default before the conditional override, so no latch is inferred.
    always_comb begin
        y_next = {1'b0, video_y} + {10'd0, hblank};
        if (y_next >= LINES_C)
            y_next = '0;
    end

    assign base_next  = ADDR_W'(y_next) * ADDR_W'(WORDS_PER_LINE);
    assign line_start = hblank & ~hblank_q;
    assign restart    = line_start & ~download;
    assign fetching   = (state == BURST) || (state == GAP);
    // A line start wins over a word arriving in the same cycle.
    assign accept     = (state == BURST) && sd_data_available && (count < WPL) && !line_start;
    assign avail_fall = avail_q & ~sd_data_available;

    assign sd_wr_req  = wr_req_in & download;
    assign sd_addr    = sd_wr_req ? wr_addr : base + ADDR_W'(count);

    // NOTE: all state below updates with non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hblank_q     <= 1'b0;
            avail_q      <= 1'b0;
            end_sent     <= 1'b0;
            count        <= '0;
            pack         <= 2'd0;
            base         <= '0;
            sd_rd_req    <= 1'b0;
            sd_end_burst <= 1'b0;
            fifo_wrreq   <= 1'b0;
            fifo_clear   <= 1'b0;
            line_done    <= 1'b0;
            bg_pixel     <= '0;
            mask_pixel   <= '0;
        end else begin
            hblank_q     <= hblank;
            avail_q      <= sd_data_available;
            sd_rd_req    <= 1'b0;
            sd_end_burst <= 1'b0;
            fifo_wrreq   <= 1'b0;
            fifo_clear   <= 1'b0;

            if (restart) begin
                // Stale availability from an aborted burst must not look like a falling edge.
                state      <= BURST;
                base       <= base_next;
                count      <= '0;
                pack       <= 2'd0;
                bg_pixel   <= '0;
                mask_pixel <= '0;
                line_done  <= 1'b0;
                end_sent   <= 1'b0;
                avail_q    <= 1'b0;
                sd_rd_req  <= 1'b1;
                fifo_clear <= 1'b1;
            end else if (download && fetching) begin
                state <= IDLE;
            end else begin
                case (state)
                    BURST: begin
                        if (accept) begin
                            bg_pixel   <= {sd_q[7:0],  bg_pixel[23:8]};
                            mask_pixel <= {sd_q[15:8], mask_pixel[23:8]};
                            count      <= count + CNT_W'(1);
                            if (pack == 2'd2) begin
                                pack       <= 2'd0;
                                fifo_wrreq <= 1'b1;
                            end else begin
                                pack <= pack + 2'd1;
                            end
                            if (count >= WPL_M2 && !end_sent) begin
                                sd_end_burst <= 1'b1;
                                end_sent     <= 1'b1;
                            end
                        end
                        if (avail_fall) begin
                            if (count < WPL) begin
                                state <= GAP;
                            end else begin
                                state     <= DONE;
                                line_done <= 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        sd_rd_req <= 1'b1;
                        end_sent  <= 1'b0;
                        state     <= BURST;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LINE_FETCH_STATS_EN
    // An underrun is any accepted line start that finds the previous line unfinished.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (restart && !(((state == DONE) || (state == IDLE)) && line_done)
                     && (underrun_count != 16'hffff)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Randomized self-checking bench for line_fetch_scheduler; expected pixels and
// addresses come from a word-level model of the scanline fetch.
module tb_line_fetch_scheduler;

    localparam int WPL    = 2160;
    localparam int LINES  = 720;
    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              reset;
    logic              hblank;
    logic [9:0]        video_y;
    logic              download;
    logic              wr_req_in;
    logic [ADDR_W-1:0] wr_addr;
    logic              sd_data_available;
    logic [15:0]       sd_q;
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_rd_req;
    logic              sd_wr_req;
    logic              sd_end_burst;
    logic              fifo_wrreq;
    logic [23:0]       bg_pixel;
    logic [23:0]       mask_pixel;
    logic              fifo_clear;
    logic              line_done;

    line_fetch_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .hblank            (hblank),
        .video_y           (video_y),
        .download          (download),
        .wr_req_in         (wr_req_in),
        .wr_addr           (wr_addr),
        .sd_data_available (sd_data_available),
        .sd_q              (sd_q),
        .sd_addr           (sd_addr),
        .sd_rd_req         (sd_rd_req),
        .sd_wr_req         (sd_wr_req),
        .sd_end_burst      (sd_end_burst),
        .fifo_wrreq        (fifo_wrreq),
        .bg_pixel          (bg_pixel),
        .mask_pixel        (mask_pixel),
        .fifo_clear        (fifo_clear),
        .line_done         (line_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: words of the current line and the pixels they must produce.
    int          m_count;
    int          exp_base;
    logic [15:0] words [WPL];
    logic [23:0] q_bg[$];
    logic [23:0] q_mask[$];
    int          n_wr, n_rd, n_clr, n_end;
    int          drove_idx = -1;
    int          last_idx  = -1;
    logic        obs_wr;
    logic [23:0] obs_bg, obs_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sd_addr"},      sd_addr,      0);
        check({tag, "_sd_rd_req"},    sd_rd_req,    0);
        check({tag, "_sd_wr_req"},    sd_wr_req,    0);
        check({tag, "_sd_end_burst"}, sd_end_burst, 0);
        check({tag, "_fifo_wrreq"},   fifo_wrreq,   0);
        check({tag, "_fifo_clear"},   fifo_clear,   0);
        check({tag, "_line_done"},    line_done,    0);
        check({tag, "_bg_pixel"},     bg_pixel,     0);
        check({tag, "_mask_pixel"},   mask_pixel,   0);
    endtask

    // Called on the falling edge: reports what the previous rising edge produced.
    task automatic observe();
        last_idx  = drove_idx;
        drove_idx = -1;
        obs_wr    = fifo_wrreq;
        if (fifo_wrreq) begin
            n_wr++;
            obs_bg   = bg_pixel;
            obs_mask = mask_pixel;
            check("wr_has_pixel", 32'(q_bg.size() != 0), 1);
            if (q_bg.size() != 0) begin
                check("bg_pixel",   bg_pixel,   q_bg.pop_front());
                check("mask_pixel", mask_pixel, q_mask.pop_front());
            end
        end
        if (sd_rd_req) begin
            n_rd++;
            check("rd_addr", sd_addr, exp_base + m_count);
        end
        if (fifo_clear) n_clr++;
        if (sd_end_burst) begin
            n_end++;
            check("end_burst_after_idx", last_idx, WPL - 2);
        end
    endtask

    task automatic drive_word(input logic av, input logic [15:0] q);
        sd_data_available = av;
        sd_q              = q;
        if (av && m_count < WPL) begin
            words[m_count] = q;
            drove_idx      = m_count;
            if (m_count % 3 == 2) begin
                q_bg.push_back({q[7:0], words[m_count-1][7:0], words[m_count-2][7:0]});
                q_mask.push_back({q[15:8], words[m_count-1][15:8], words[m_count-2][15:8]});
            end
            m_count++;
        end
    endtask

    task automatic step(input logic av, input logic [15:0] q);
        @(negedge clk);
        observe();
        drive_word(av, q);
    endtask

    task automatic start_line(input int y, input logic av, input logic [15:0] q);
        @(negedge clk);
        observe();
        hblank            = 1'b1;
        video_y           = 10'(y);
        sd_data_available = av;
        sd_q              = q;
        q_bg.delete();
        q_mask.delete();
        m_count  = 0;
        exp_base = ((y + 1 >= LINES) ? 0 : y + 1) * WPL;
        n_wr = 0; n_rd = 0; n_clr = 0; n_end = 0;
        step(1'b0, 16'h0);
        check("start_rd_req", n_rd, 1);
        check("start_clear",  n_clr, 1);
        hblank = 1'b0;
        repeat ($urandom_range(0, 2)) step(1'b0, 16'h0);
    endtask

    task automatic feed(input int upto);
        while (m_count < upto) step(1'b1, 16'($urandom));
    endtask

    task automatic gap();
        int r0;
        int k;
        r0 = n_rd;
        k  = 0;
        step(1'b0, 16'h0);
        while (n_rd == r0 && k < 20) begin
            step(1'b0, 16'h0);
            k++;
        end
        check("gap_resume_rd", n_rd - r0, 1);
        repeat ($urandom_range(0, 2)) step(1'b0, 16'h0);
    endtask

    task automatic finish_line(input int extra, input int exp_rd);
        repeat (extra) step(1'b1, 16'($urandom));
        repeat (4) step(1'b0, 16'h0);
        check("line_done",   line_done, 1);
        check("wrreq_count", n_wr, WPL / 3);
        check("end_count",   n_end, 1);
        check("pixels_left", q_bg.size(), 0);
        check("rd_count",    n_rd, exp_rd);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int g1, g2;
        reset = 1'b1; hblank = 1'b0; video_y = '0; download = 1'b0;
        wr_req_in = 1'b0; wr_addr = '0; sd_data_available = 1'b0; sd_q = '0;
        m_count = 0; exp_base = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) step(1'b0, 16'h0);

        // Line after y=5, with the known packing words up front.
        start_line(5, 1'b0, 16'h0);
        step(1'b1, 16'h1122);
        step(1'b1, 16'h3344);
        step(1'b1, 16'h5566);
        step(1'b1, 16'($urandom));
        check("first_wr",   obs_wr,   1);
        check("first_bg",   obs_bg,   24'h664422);
        check("first_mask", obs_mask, 24'h553311);
        feed(WPL);
        finish_line(0, 1);

        // Availability drops after 100 words; resume must address base+100.
        start_line(100, 1'b0, 16'h0);
        feed(100);
        gap();
        feed(WPL);
        finish_line(0, 2);

        // Last visible line wraps to line 0; surplus words are discarded.
        start_line(719, 1'b0, 16'h0);
        feed(WPL);
        finish_line(5, 1);

        // Download write with a coincident line start.
        @(negedge clk);
        observe();
        n_rd = 0; n_clr = 0;
        download = 1'b1; wr_req_in = 1'b1; wr_addr = 25'h1234;
        hblank = 1'b1; video_y = 10'd3;
        #1;
        check("dl_wr_req", sd_wr_req, 1);
        check("dl_addr",   sd_addr,   25'h1234);
        repeat (4) step(1'b0, 16'h0);
        check("dl_no_rd",    n_rd,      0);
        check("dl_no_clear", n_clr,     0);
        check("dl_held_done", line_done, 1);
        wr_req_in = 1'b0; hblank = 1'b0; download = 1'b0;
        repeat (2) step(1'b0, 16'h0);

        // Download rising mid-fetch aborts without further reads.
        start_line(20, 1'b0, 16'h0);
        feed(30);
        step(1'b0, 16'h0);
        download = 1'b1;
        repeat (10) step(1'b0, 16'h0);
        check("abort_rd_count", n_rd, 1);
        check("abort_wr_count", n_wr, 10);
        check("abort_left",     q_bg.size(), 0);
        download = 1'b0;
        step(1'b0, 16'h0);

        // New line start during a burst restarts; the coincident word is dropped.
        start_line(30, 1'b0, 16'h0);
        feed(40);
        start_line(31, 1'b1, 16'($urandom));
        feed($urandom_range(10, 2000));
        gap();
        feed(WPL);
        finish_line(0, 2);

        // Reset in the middle of a burst, then a clean line.
        start_line(10, 1'b0, 16'h0);
        feed(50);
        @(negedge clk);
        reset = 1'b1;
        sd_data_available = 1'b0;
        #1;
        check_all_zero("midreset");
        q_bg.delete();
        q_mask.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start_line(200, 1'b0, 16'h0);
        feed(WPL);
        finish_line(0, 1);

        // Random lines with two random gaps each.
        for (int i = 0; i < 2; i++) begin
            g1 = $urandom_range(1, 700);
            g2 = $urandom_range(701, 2150);
            start_line($urandom_range(0, 719), 1'b0, 16'h0);
            feed(g1);
            gap();
            feed(g2);
            gap();
            feed(WPL);
            finish_line($urandom_range(0, 3), 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
